controller_op_stack: RTL and testbench

- LIFO operator stack directly downstream of the controller's operator register.
- The controller pushes the parsed operator code (`CO_AD/`CO_SB/`CO_MU/`CO_DI/`CO_LP/`CO_RP) or pops/replaces the top during precedence reduction.
- Supplies op_data/op_empty back to the controller and the precedence ROM.
- Tracks overflow/underflow as sticky errors for the controller's error state.

---
 rtl/controller_op_stack.sv | 164 ++++++++++++++++
 tb/tb_controller_op_stack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_op_stack.sv
// Operator stack (LIFO) that sits after the controller's operator register.
// The top of stack is held in its own register, so op_data comes straight from
// a flop. Overflow and underflow are sticky error flags.
// Optional feature: define OPSTACK_PEEK2_EN to add op_next, a registered copy
// of the entry just below the top.

`ifndef CO_N
`define CO_N 3
`endif
`ifndef CO_AD
`define CO_AD 3'd0
`endif
`ifndef CO_SB
`define CO_SB 3'd1
`endif
`ifndef CO_MU
`define CO_MU 3'd2
`endif
`ifndef CO_DI
`define CO_DI 3'd3
`endif
`ifndef CO_LP
`define CO_LP 3'd4
`endif
`ifndef CO_RP
`define CO_RP 3'd5
`endif

module controller_op_stack #(
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [`CO_N-1:0]     push_data,
    output logic [`CO_N-1:0]     op_data,
    output logic                 op_empty,
    output logic                 op_full,
    output logic [DEPTH_LOG:0]   op_count,
    output logic                 op_overflow,
    output logic                 op_underflow
`ifdef OPSTACK_PEEK2_EN
    ,
    output logic [`CO_N-1:0]     op_next
`endif
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] SP_ONE  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG:0] SP_TWO  = (DEPTH_LOG + 1)'(2);
    localparam logic [DEPTH_LOG:0] SP_FULL = (DEPTH_LOG + 1)'(DEPTH);

    logic [`CO_N-1:0]   stack_q [DEPTH];
    logic [DEPTH_LOG:0] sp_q, sp_d;
    logic [`CO_N-1:0]   top_q, top_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               wr_en;
    logic [DEPTH_LOG-1:0] wr_idx;
    logic [DEPTH_LOG-1:0] idx_lo, idx_m1, idx_m2;
    logic               is_empty, is_full;

    assign idx_lo   = sp_q[DEPTH_LOG-1:0];
    assign idx_m1   = idx_lo - DEPTH_LOG'(1);
    assign idx_m2   = idx_lo - DEPTH_LOG'(2);
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);

`ifdef OPSTACK_PEEK2_EN
    localparam logic [DEPTH_LOG:0] SP_THREE = (DEPTH_LOG + 1)'(3);
    logic [`CO_N-1:0]     next_q, next_d;
    logic [DEPTH_LOG-1:0] idx_m3;
    assign idx_m3 = idx_lo - DEPTH_LOG'(3);
`endif

    // Next-state decode of clear / push / pop; push+pop on empty acts as push
    always_comb begin
        sp_d   = sp_q;
        top_d  = top_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = idx_lo;
`ifdef OPSTACK_PEEK2_EN
        next_d = next_q;
`endif
        if (clear) begin
            sp_d  = '0;
            top_d = `CO_AD;
            ovf_d = 1'b0;
            unf_d = 1'b0;
`ifdef OPSTACK_PEEK2_EN
            next_d = `CO_AD;
`endif
        end else if (push && (!pop || is_empty)) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = Reset;
                sp_d  = sp_q + SP_ONE;
                top_d = push_data;
`ifdef OPSTACK_PEEK2_EN
                next_d = is_empty ? `CO_AD : top_q;
`endif
            end
        end else if (push && pop) begin
            // Replace top in place; count and entry below are unchanged
            wr_en  = Reset;
            wr_idx = idx_m1;
            top_d  = push_data;
        end else if (pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d  = sp_q - SP_ONE;
                top_d = (sp_q >= SP_TWO) ? stack_q[idx_m2] : `CO_AD;
`ifdef OPSTACK_PEEK2_EN
                next_d = (sp_q >= SP_THREE) ? stack_q[idx_m3] : `CO_AD;
`endif
            end
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sp_q  <= '0;
            top_q <= `CO_AD;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef OPSTACK_PEEK2_EN
            next_q <= `CO_AD;
`endif
        end else begin
            sp_q  <= sp_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
`ifdef OPSTACK_PEEK2_EN
            next_q <= next_d;
`endif
        end
    end

    // Entry storage; contents need no reset since sp gates every read
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            stack_q[wr_idx] <= push_data;
        end
    end

    assign op_data      = top_q;
    assign op_empty     = is_empty;
    assign op_full      = is_full;
    assign op_count     = sp_q;
    assign op_overflow  = ovf_q;
    assign op_underflow = unf_q;
`ifdef OPSTACK_PEEK2_EN
    assign op_next      = next_q;
`endif

endmodule

// File: tb/tb_controller_op_stack.sv
// Bench for controller_op_stack: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.

`ifndef CO_N
`define CO_N 3
`endif
`ifndef CO_AD
`define CO_AD 3'd0
`endif
`ifndef CO_SB
`define CO_SB 3'd1
`endif
`ifndef CO_MU
`define CO_MU 3'd2
`endif
`ifndef CO_DI
`define CO_DI 3'd3
`endif
`ifndef CO_LP
`define CO_LP 3'd4
`endif
`ifndef CO_RP
`define CO_RP 3'd5
`endif

module tb_controller_op_stack;

    localparam int DEPTH_LOG = 3;
    localparam int DEPTH     = 8;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic               clear = 1'b0;
    logic               push  = 1'b0;
    logic               pop   = 1'b0;
    logic [`CO_N-1:0]   push_data = '0;
    logic [`CO_N-1:0]   op_data;
    logic               op_empty;
    logic               op_full;
    logic [DEPTH_LOG:0] op_count;
    logic               op_overflow;
    logic               op_underflow;
`ifdef OPSTACK_PEEK2_EN
    logic [`CO_N-1:0]   op_next;
`endif

    controller_op_stack #(.DEPTH_LOG(DEPTH_LOG)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .push_data    (push_data),
        .op_data      (op_data),
        .op_empty     (op_empty),
        .op_full      (op_full),
        .op_count     (op_count),
        .op_overflow  (op_overflow),
        .op_underflow (op_underflow)
`ifdef OPSTACK_PEEK2_EN
        ,
        .op_next      (op_next)
`endif
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue, back = top of stack
    logic [`CO_N-1:0] m_stk [$];
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit pu, input bit po,
                                input logic [`CO_N-1:0] d);
        if (!r || c) begin
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (pu && (!po || m_stk.size() == 0)) begin
            if (m_stk.size() == DEPTH) m_ovf = 1;
            else m_stk.push_back(d);
        end else if (pu && po) begin
            m_stk[m_stk.size() - 1] = d;
        end else if (po) begin
            if (m_stk.size() == 0) m_unf = 1;
            else void'(m_stk.pop_back());
        end
    endtask

    task automatic compare_all();
        int n;
        int exp_top;
        n = m_stk.size();
        exp_top = (n > 0) ? int'(m_stk[n - 1]) : int'(`CO_AD);
        chk("op_count", int'(op_count), n);
        chk("op_data", int'(op_data), exp_top);
        chk("op_empty", int'(op_empty), (n == 0) ? 1 : 0);
        chk("op_full", int'(op_full), (n == DEPTH) ? 1 : 0);
        chk("op_overflow", int'(op_overflow), int'(m_ovf));
        chk("op_underflow", int'(op_underflow), int'(m_unf));
`ifdef OPSTACK_PEEK2_EN
        chk("op_next", int'(op_next), (n >= 2) ? int'(m_stk[n - 2]) : int'(`CO_AD));
`endif
    endtask

    // Drive one cycle on the falling edge, then check just after the rising edge
    task automatic step(input bit r, input bit c, input bit pu, input bit po,
                        input logic [`CO_N-1:0] d);
        @(negedge Clock);
        Reset     = r;
        clear     = c;
        push      = pu;
        pop       = po;
        push_data = d;
        @(posedge Clock);
        model_update(r, c, pu, po, d);
        #1;
        compare_all();
    endtask

    logic [`CO_N-1:0] fill [8];

    initial begin
        int push_pct;
        fill[0] = `CO_SB; fill[1] = `CO_MU; fill[2] = `CO_DI; fill[3] = `CO_LP;
        fill[4] = `CO_RP; fill[5] = `CO_AD; fill[6] = `CO_MU; fill[7] = `CO_SB;

        // Reset with push asserted: push is discarded
        step(0, 0, 1, 0, `CO_MU);
        chk("rst_count", int'(op_count), 0);
        chk("rst_empty", int'(op_empty), 1);
        chk("rst_data", int'(op_data), int'(`CO_AD));
        chk("rst_ovf", int'(op_overflow), 0);
        chk("rst_unf", int'(op_underflow), 0);

        // Push AD, MU, LP then pop three times
        step(1, 0, 1, 0, `CO_AD);
        chk("p1_count", int'(op_count), 1);
        chk("p1_data", int'(op_data), int'(`CO_AD));
        step(1, 0, 1, 0, `CO_MU);
        chk("p2_count", int'(op_count), 2);
        chk("p2_data", int'(op_data), int'(`CO_MU));
        step(1, 0, 1, 0, `CO_LP);
        chk("p3_count", int'(op_count), 3);
        chk("p3_data", int'(op_data), int'(`CO_LP));
        step(1, 0, 0, 1, `CO_AD);
        chk("q1_data", int'(op_data), int'(`CO_MU));
        step(1, 0, 0, 1, `CO_AD);
        chk("q2_data", int'(op_data), int'(`CO_AD));
        step(1, 0, 0, 1, `CO_AD);
        chk("q3_data", int'(op_data), int'(`CO_AD));
        chk("q3_empty", int'(op_empty), 1);

        // Fill to DEPTH then overflow
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, fill[i]);
        step(1, 0, 1, 0, `CO_DI);
        chk("ovf_full", int'(op_full), 1);
        chk("ovf_count", int'(op_count), 8);
        chk("ovf_flag", int'(op_overflow), 1);
        chk("ovf_data", int'(op_data), int'(`CO_SB));
        step(1, 0, 0, 1, `CO_AD);
        chk("ovf_sticky", int'(op_overflow), 1);
        chk("ovf_pop_data", int'(op_data), int'(`CO_MU));

        // Underflow, then push+pop on empty
        step(1, 1, 0, 0, `CO_AD);
        step(1, 0, 1, 1, `CO_SB);
        chk("pp_empty_unf", int'(op_underflow), 0);
        chk("pp_empty_count", int'(op_count), 1);
        step(1, 1, 0, 0, `CO_AD);
        step(1, 0, 0, 1, `CO_AD);
        chk("unf_flag", int'(op_underflow), 1);
        chk("unf_count", int'(op_count), 0);
        step(1, 0, 1, 1, `CO_SB);
        chk("pp_count", int'(op_count), 1);
        chk("pp_data", int'(op_data), int'(`CO_SB));
        chk("pp_unf", int'(op_underflow), 1);

        // Replace top
        step(1, 1, 0, 0, `CO_AD);
        step(1, 0, 1, 0, `CO_AD);
        step(1, 0, 1, 0, `CO_MU);
        step(1, 0, 1, 1, `CO_DI);
        chk("rep_count", int'(op_count), 2);
        chk("rep_data", int'(op_data), int'(`CO_DI));
        step(1, 0, 0, 1, `CO_AD);
        chk("rep_pop_data", int'(op_data), int'(`CO_AD));

        // Errors set, count 5, then clear with push
        step(1, 1, 0, 0, `CO_AD);
        step(1, 0, 0, 1, `CO_AD);
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, fill[i % 8]);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, `CO_AD);
        chk("pre_clr_count", int'(op_count), 5);
        step(1, 1, 1, 0, `CO_MU);
        chk("clr_count", int'(op_count), 0);
        chk("clr_empty", int'(op_empty), 1);
        chk("clr_ovf", int'(op_overflow), 0);
        chk("clr_unf", int'(op_underflow), 0);

`ifdef OPSTACK_PEEK2_EN
        step(1, 0, 1, 0, `CO_LP);
        step(1, 0, 1, 0, `CO_AD);
        chk("peek_lp", int'(op_next), int'(`CO_LP));
`endif

        // Randomized traffic with a push bias that drifts between phases
        for (int i = 0; i < 3000; i++) begin
            bit r, c, pu, po;
            if ((i % 250) == 0) push_pct = $urandom_range(15, 85);
            r  = ($urandom_range(0, 299) != 0);
            c  = ($urandom_range(0, 149) == 0);
            pu = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < (100 - push_pct));
            step(r, c, pu, po, `CO_N'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
